encoder_period_meter: RTL and testbench

Quadrature encoder front end for the BLDC speed loop. It synchronizes and deglitches the encoder A/B pins, then decodes direction and a 4x position count. It also measures the period between successive encoder-A rising edges in clock ticks and provides a moving average of that period. It sits directly upstream of the speed PID, which compares its output against the I2C-programmed 16-bit period reference.

---
 rtl/encoder_period_meter.sv | 241 ++++++++++++++++++++++++
 tb/tb_encoder_period_meter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/encoder_period_meter.sv
// -----------------------------------------------------------------------------
// encoder_period_meter
//
// Quadrature encoder front end for the BLDC speed loop. Synchronizes and
// deglitches the A/B pins, decodes direction and a 4x position count, and
// measures the period between filtered A rising edges together with a moving
// average over 2^AVG_SHIFT periods.
//
// Ports:
//   clk             system clock
//   rst             asynchronous active-low reset
//   enable          period measurement enable (decode always runs)
//   encoder_a/b     raw asynchronous encoder channels
//   period_measured latest A-to-A period in clk ticks, saturated at 16'hFFFF
//   period_avg      moving average of the last 2^AVG_SHIFT periods
//   period_valid    one-cycle strobe, both period outputs updated
//   direction       1 = forward (A leads B), 0 = reverse
//   position_count  signed 4x quadrature count, wraps modulo 2^16
//   stalled         no A rising edge within STALL_LIMIT ticks
//   quad_error      one-cycle strobe when A and B change together
// -----------------------------------------------------------------------------
module encoder_period_meter #(
   parameter int unsigned FILTER_LEN  = 4,
   parameter int unsigned AVG_SHIFT   = 2,
   parameter logic [15:0] STALL_LIMIT = 16'hFFFF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic        encoder_a,
   input  logic        encoder_b,
   output logic [15:0] period_measured,
   output logic [15:0] period_avg,
   output logic        period_valid,
   output logic        direction,
   output logic [15:0] position_count,
   output logic        stalled,
   output logic        quad_error
);

   localparam int          DEPTH    = 1 << AVG_SHIFT;
   localparam int          SUM_W    = 16 + AVG_SHIFT;
   localparam int          PTR_W    = (AVG_SHIFT > 0) ? AVG_SHIFT : 1;
   localparam logic [3:0]  FILT_THR = 4'(FILTER_LEN);

   typedef enum logic [1:0] {S_IDLE, S_ARMING, S_MEASURING, S_STALLED} state_t;

   // Channel bit 1 = A, bit 0 = B throughout.
   logic [1:0]       sync1_q, sync2_q, sync3_q;
   logic [3:0]       flt_cnt_q [2];
   logic [3:0]       flt_cnt_d [2];
   logic [1:0]       filt_q, filt_d, filt_prev_q;

   logic [15:0]      pos_q, pos_d;
   logic             dir_q, dir_d, qerr_q, qerr_d;

   state_t           state_q, state_d;
   logic [15:0]      tick_q, tick_d;
   logic             stalled_q, stalled_d;
   logic [15:0]      meas_q, meas_d, avg_q, avg_d;
   logic             valid_q, valid_d;
   logic             hist_valid_q, hist_valid_d;
   logic [SUM_W-1:0] sum_q, sum_d;
   logic [PTR_W-1:0] ptr_q, ptr_d;
   logic [15:0]      buf_q [DEPTH];
   logic [15:0]      buf_d [DEPTH];

   logic             a_rise;
   logic [15:0]      sample;

   // Next value in the forward Gray sequence 00->10->11->01->00.
   function automatic logic [1:0] fwd_next(input logic [1:0] ab);
      case (ab)
         2'b00:   fwd_next = 2'b10;
         2'b10:   fwd_next = 2'b11;
         2'b11:   fwd_next = 2'b01;
         default: fwd_next = 2'b00;
      endcase
   endfunction

   // Filter: count the run length of the synchronized value; the filtered
   // value follows once the run reaches FILTER_LEN cycles.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      flt_cnt_d = flt_cnt_q;
      filt_d    = filt_q;
      for (int i = 0; i < 2; i++) begin
         if (sync2_q[i] != sync3_q[i])    flt_cnt_d[i] = 4'd1;
         else if (flt_cnt_q[i] != 4'hF)   flt_cnt_d[i] = flt_cnt_q[i] + 4'd1;
         if (flt_cnt_d[i] >= FILT_THR)    filt_d[i]    = sync2_q[i];
      end
   end

   // Quadrature decode on the filtered pair.
   always_comb begin
      pos_d  = pos_q;
      dir_d  = dir_q;
      qerr_d = 1'b0;
      if (filt_q != filt_prev_q) begin
         if ((filt_q ^ filt_prev_q) == 2'b11) begin
            qerr_d = 1'b1;
         end else if (filt_q == fwd_next(filt_prev_q)) begin
            pos_d = pos_q + 16'd1;
            dir_d = 1'b1;
         end else begin
            pos_d = pos_q - 16'd1;
            dir_d = 1'b0;
         end
      end
   end

   assign a_rise = filt_q[1] & ~filt_prev_q[1];
   // Counter is cleared on the edge cycle, so the edge distance is count + 1.
   assign sample = (tick_q == 16'hFFFF) ? 16'hFFFF : tick_q + 16'd1;

   // Period FSM and averaging.
   always_comb begin
      state_d      = state_q;
      tick_d       = tick_q;
      stalled_d    = stalled_q;
      meas_d       = meas_q;
      avg_d        = avg_q;
      valid_d      = 1'b0;
      hist_valid_d = hist_valid_q;
      sum_d        = sum_q;
      ptr_d        = ptr_q;
      buf_d        = buf_q;
      if (!enable) begin
         state_d   = S_IDLE;
         tick_d    = '0;
         stalled_d = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               tick_d  = '0;
               state_d = S_ARMING;
            end
            S_ARMING: begin
               hist_valid_d = 1'b0;
               if (a_rise) begin
                  tick_d  = '0;
                  state_d = S_MEASURING;
               end
            end
            S_MEASURING: begin
               // An edge on the stall-limit cycle wins over the stall.
               if (a_rise) begin
                  tick_d  = '0;
                  meas_d  = sample;
                  valid_d = 1'b1;
                  if (!hist_valid_q) begin
                     for (int i = 0; i < DEPTH; i++) buf_d[i] = sample;
                     sum_d        = SUM_W'(sample) << AVG_SHIFT;
                     ptr_d        = '0;
                     hist_valid_d = 1'b1;
                  end else begin
                     sum_d        = sum_q - SUM_W'(buf_q[ptr_q]) + SUM_W'(sample);
                     buf_d[ptr_q] = sample;
                     ptr_d        = (ptr_q == PTR_W'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
                  end
                  avg_d = 16'(sum_d >> AVG_SHIFT);
               end else if (tick_q == STALL_LIMIT) begin
                  state_d      = S_STALLED;
                  stalled_d    = 1'b1;
                  meas_d       = 16'hFFFF;
                  avg_d        = 16'hFFFF;
                  valid_d      = 1'b1;
                  hist_valid_d = 1'b0;
               end else if (tick_q != 16'hFFFF) begin
                  tick_d = tick_q + 16'd1;
               end
            end
            S_STALLED: begin
               if (a_rise) begin
                  stalled_d = 1'b0;
                  tick_d    = '0;
                  state_d   = S_MEASURING;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_q      <= '0;
         sync2_q      <= '0;
         sync3_q      <= '0;
         flt_cnt_q    <= '{default: '0};
         filt_q       <= '0;
         filt_prev_q  <= '0;
         pos_q        <= '0;
         dir_q        <= 1'b0;
         qerr_q       <= 1'b0;
         state_q      <= S_IDLE;
         tick_q       <= '0;
         stalled_q    <= 1'b0;
         meas_q       <= 16'hFFFF;
         avg_q        <= 16'hFFFF;
         valid_q      <= 1'b0;
         hist_valid_q <= 1'b0;
         sum_q        <= '0;
         ptr_q        <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         sync1_q      <= {encoder_a, encoder_b};
         sync2_q      <= sync1_q;
         sync3_q      <= sync2_q;
         flt_cnt_q    <= flt_cnt_d;
         filt_q       <= filt_d;
         filt_prev_q  <= filt_q;
         pos_q        <= pos_d;
         dir_q        <= dir_d;
         qerr_q       <= qerr_d;
         state_q      <= state_d;
         tick_q       <= tick_d;
         stalled_q    <= stalled_d;
         meas_q       <= meas_d;
         avg_q        <= avg_d;
         valid_q      <= valid_d;
         hist_valid_q <= hist_valid_d;
         sum_q        <= sum_d;
         ptr_q        <= ptr_d;
      end
   end

   // NOTE: the history buffer has no reset; it is always preloaded before use.
   always_ff @(posedge clk) begin
      buf_q <= buf_d;
   end

   assign period_measured = meas_q;
   assign period_avg      = avg_q;
   assign period_valid    = valid_q;
   assign direction       = dir_q;
   assign position_count  = pos_q;
   assign stalled         = stalled_q;
   assign quad_error      = qerr_q;

endmodule

// File: tb/tb_encoder_period_meter.sv
// -----------------------------------------------------------------------------
// tb_encoder_period_meter
//
// Directed bench for encoder_period_meter (FILTER_LEN=4, AVG_SHIFT=2,
// STALL_LIMIT=5000). A monitor records every period_valid strobe and counts
// quad_error cycles; the main sequence drives quadrature waveforms and checks
// the recorded results against hand-computed values.
// -----------------------------------------------------------------------------
module tb_encoder_period_meter;

   logic        clk, rst, enable, encoder_a, encoder_b;
   logic [15:0] period_measured, period_avg, position_count;
   logic        period_valid, direction, stalled, quad_error;

   typedef struct packed {
      logic [15:0] meas;
      logic [15:0] avg;
   } strobe_t;

   strobe_t strobes[$];
   int      qerr_cnt;
   int      test_cnt;
   int      fail_cnt;

   encoder_period_meter #(
      .FILTER_LEN (4),
      .AVG_SHIFT  (2),
      .STALL_LIMIT(16'd5000)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .enable         (enable),
      .encoder_a      (encoder_a),
      .encoder_b      (encoder_b),
      .period_measured(period_measured),
      .period_avg     (period_avg),
      .period_valid   (period_valid),
      .direction      (direction),
      .position_count (position_count),
      .stalled        (stalled),
      .quad_error     (quad_error)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(negedge clk) begin
      if (period_valid) strobes.push_back('{meas: period_measured, avg: period_avg});
      if (quad_error)   qerr_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      test_cnt++;
      assert (obs === exp) else begin
         fail_cnt++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // n full periods of p ticks; forward = A leads B.
   task automatic run_quad(input int p, input bit fwd, input int n);
      int q = p / 4;
      for (int k = 0; k < n; k++) begin
         if (fwd) begin
            {encoder_a, encoder_b} = 2'b10; tick(q);
            {encoder_a, encoder_b} = 2'b11; tick(q);
            {encoder_a, encoder_b} = 2'b01; tick(q);
            {encoder_a, encoder_b} = 2'b00; tick(q);
         end else begin
            {encoder_a, encoder_b} = 2'b01; tick(q);
            {encoder_a, encoder_b} = 2'b11; tick(q);
            {encoder_a, encoder_b} = 2'b10; tick(q);
            {encoder_a, encoder_b} = 2'b00; tick(q);
         end
      end
   endtask

   task automatic rearm();
      enable = 1'b0;
      tick(5);
      enable = 1'b1;
      tick(5);
   endtask

   initial begin
      logic [15:0] exp_meas [9];
      logic [15:0] exp_avg  [9];
      int waited;

      test_cnt  = 0;
      fail_cnt  = 0;
      qerr_cnt  = 0;
      rst       = 1'b0;
      enable    = 1'b0;
      encoder_a = 1'b0;
      encoder_b = 1'b0;
      tick(3);

      // Reset state
      check("rst_meas",    32'(period_measured), 32'hFFFF);
      check("rst_avg",     32'(period_avg),      32'hFFFF);
      check("rst_valid",   32'(period_valid),    32'd0);
      check("rst_dir",     32'(direction),       32'd0);
      check("rst_pos",     32'(position_count),  32'd0);
      check("rst_stalled", 32'(stalled),         32'd0);
      check("rst_qerr",    32'(quad_error),      32'd0);

      rst = 1'b1;
      tick(3);
      enable = 1'b1;
      tick(5);

      // Forward, 1000-tick period: 5 A edges -> 4 strobes
      strobes.delete();
      run_quad(1000, 1'b1, 5);
      check("fwd_strobes", 32'(strobes.size()), 32'd4);
      for (int i = 0; i < strobes.size(); i++) begin
         check("fwd_meas", 32'(strobes[i].meas), 32'd1000);
         check("fwd_avg",  32'(strobes[i].avg),  32'd1000);
      end
      check("fwd_dir", 32'(direction),      32'd1);
      check("fwd_pos", 32'(position_count), 32'd20);

      // Reverse, 6 periods: 5 strobes, position 20 - 24 = -4
      rearm();
      strobes.delete();
      run_quad(1000, 1'b0, 6);
      check("rev_strobes", 32'(strobes.size()), 32'd5);
      for (int i = 0; i < strobes.size(); i++) begin
         check("rev_meas", 32'(strobes[i].meas), 32'd1000);
         check("rev_avg",  32'(strobes[i].avg),  32'd1000);
      end
      check("rev_dir", 32'(direction),      32'd0);
      check("rev_pos", 32'(position_count), 32'hFFFC);

      // 3-cycle glitch on A is rejected
      strobes.delete();
      encoder_a = 1'b1;
      tick(3);
      encoder_a = 1'b0;
      tick(30);
      check("glitch_strobes", 32'(strobes.size()), 32'd0);
      check("glitch_pos",     32'(position_count), 32'hFFFC);
      check("glitch_qerr",    32'(qerr_cnt),       32'd0);

      // Period step 1000 -> 2000
      rearm();
      strobes.delete();
      run_quad(1000, 1'b1, 5);
      run_quad(2000, 1'b1, 5);
      exp_meas = '{16'd1000, 16'd1000, 16'd1000, 16'd1000, 16'd1000,
                   16'd2000, 16'd2000, 16'd2000, 16'd2000};
      exp_avg  = '{16'd1000, 16'd1000, 16'd1000, 16'd1000, 16'd1000,
                   16'd1250, 16'd1500, 16'd1750, 16'd2000};
      check("step_strobes", 32'(strobes.size()), 32'd9);
      for (int i = 0; i < strobes.size() && i < 9; i++) begin
         check("step_meas", 32'(strobes[i].meas), 32'(exp_meas[i]));
         check("step_avg",  32'(strobes[i].avg),  32'(exp_avg[i]));
      end
      check("step_pos", 32'(position_count), 32'h0024);

      // Stall: last A edge was 2000 ticks ago, limit 5000
      strobes.delete();
      tick(2900);
      check("stall_early", 32'(stalled), 32'd0);
      waited = 0;
      while (!stalled && waited < 300) begin
         tick(1);
         waited++;
      end
      check("stall_seen", 32'(stalled), 32'd1);
      check("stall_time", 32'(waited >= 100 && waited <= 115), 32'd1);
      tick(2);
      check("stall_strobes", 32'(strobes.size()), 32'd1);
      for (int i = 0; i < strobes.size(); i++) begin
         check("stall_meas", 32'(strobes[i].meas), 32'hFFFF);
         check("stall_avg",  32'(strobes[i].avg),  32'hFFFF);
      end

      // Recovery: first edge clears stall silently, second edge strobes 1000
      strobes.delete();
      run_quad(1000, 1'b1, 2);
      check("recover_stalled", 32'(stalled),        32'd0);
      check("recover_strobes", 32'(strobes.size()), 32'd1);
      for (int i = 0; i < strobes.size(); i++) begin
         check("recover_meas", 32'(strobes[i].meas), 32'd1000);
         check("recover_avg",  32'(strobes[i].avg),  32'd1000);
      end
      check("recover_pos", 32'(position_count), 32'h002C);

      // Illegal transition: A and B together
      check("pre_qerr", 32'(qerr_cnt), 32'd0);
      {encoder_a, encoder_b} = 2'b11;
      tick(20);
      check("qerr_cycles", 32'(qerr_cnt),       32'd1);
      check("qerr_pos",    32'(position_count), 32'h002C);
      check("qerr_dir",    32'(direction),      32'd1);

      // Asynchronous reset mid-period
      tick(100);
      rst = 1'b0;
      #1;
      check("arst_meas",    32'(period_measured), 32'hFFFF);
      check("arst_avg",     32'(period_avg),      32'hFFFF);
      check("arst_valid",   32'(period_valid),    32'd0);
      check("arst_dir",     32'(direction),       32'd0);
      check("arst_pos",     32'(position_count),  32'd0);
      check("arst_stalled", 32'(stalled),         32'd0);
      check("arst_qerr",    32'(quad_error),      32'd0);
      tick(2);
      rst = 1'b1;
      tick(2);

      $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
      $finish;
   end

endmodule
